// File: rtl/prio_arb_reg_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg : shared types and helpers for the registered priority arbiter.
//   arb_state_e  : ST_IDLE (no owner) / ST_GRANT (owner held in idx register)
//   clog2_min1() : index width helper, never returns less than 1 bit
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e;

  // An index into a 2-entry (or smaller) vector still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_arb_reg_if.sv
// -----------------------------------------------------------------------------
// prio_arb_reg_if : requester/sink bundle of the registered priority arbiter.
//   req_i   [N]      level request per requester
//   data_i  [N*W]    packed data, requester k at [k*W +: W]
//   gnt_o   [N]      one-hot grant
//   idx_o   [IW]     current owner index
//   valid_o          grant active
//   data_o  [W]      owner's data word
// modport slave  : arbiter side
// modport master : requester/sink side (drives requests, observes grant)
// -----------------------------------------------------------------------------
interface prio_arb_reg_if
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = clog2_min1(N);

  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   gnt_o;
  logic [IW-1:0]  idx_o;
  logic           valid_o;
  logic [W-1:0]   data_o;

  modport slave  (input  req_i, data_i,
                  output gnt_o, idx_o, valid_o, data_o);
  modport master (output req_i, data_i,
                  input  gnt_o, idx_o, valid_o, data_o);
endinterface

// File: rtl/prio_arb_reg_pick.sv
// -----------------------------------------------------------------------------
// prio_pick : combinational find-first-set with rotating start point.
//   req_i    [N]   candidate requests (already masked by caller)
//   start_i  [IW]  first index searched; search wraps N-1 -> 0
//   found_o        any candidate set
//   idx_o    [IW]  winning index (0 when none)
//   onehot_o [N]   winning index as one-hot (0 when none)
// -----------------------------------------------------------------------------
module prio_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    int k;
    k        = 0;
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start_i) + i) % N;
      if (!found_o && req_i[k]) begin
        found_o     = 1'b1;
        idx_o       = IW'(k);
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arb_reg.sv
// -----------------------------------------------------------------------------
// prio_arb_reg : registered N-way priority arbiter with hold limit.
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : prio_arb_reg_if.slave (req_i, data_i in; gnt_o, idx_o, valid_o,
//            data_o out, all outputs registered)
// The owner keeps the grant while it requests, up to MAX_HOLD consecutive
// cycles; at the limit its own request is masked out for one arbitration so
// others get a turn (or the bus idles one cycle if nobody else is asking).
// Macro ARB_ROUND_ROBIN_EN: search starts at rr_ptr (one past last new owner)
// instead of fixed index-0-first priority.
// -----------------------------------------------------------------------------
module prio_arb_reg
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  prio_arb_reg_if.slave bus
);

  localparam int IW = clog2_min1(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [N-1:0]     gnt_q,   gnt_d;
  logic [HW-1:0]    hold_q,  hold_d;
  logic [W-1:0]     data_q,  data_d;

  logic [N-1:0][W-1:0] data_arr;
  logic [N-1:0]        mask;
  logic [IW-1:0]       start;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [N-1:0]        pick_onehot;
  logic                owner_req;
  logic                keep;
  logic                new_grant;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign data_arr[k] = bus.data_i[k*W +: W];
  end

  assign owner_req = (state_q == ST_GRANT) && bus.req_i[idx_q];
  assign keep      = owner_req && (hold_q < HW'(MAX_HOLD));

  // Only reached with the owner still requesting when the hold limit hit:
  // hide the owner so someone else can win. A dropped owner is already 0.
  always_comb begin
    mask = '1;
    if (owner_req) mask[idx_q] = 1'b0;
  end

  prio_pick #(.N(N)) u_pick (
    .req_i    (bus.req_i & mask),
    .start_i  (start),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    data_d    = '0;
    new_grant = 1'b0;
    if (keep) begin
      hold_d = hold_q + HW'(1);
      data_d = data_arr[idx_q];
    end else if (pick_found) begin
      state_d   = ST_GRANT;
      idx_d     = pick_idx;
      gnt_d     = pick_onehot;
      hold_d    = HW'(1);
      data_d    = data_arr[pick_idx];
      new_grant = 1'b1;
    end else begin
      state_d = ST_IDLE;
      idx_d   = '0;
      gnt_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_q, rr_d;

  // Pointer only moves when ownership changes hands, not while holding.
  always_comb begin
    rr_d = rr_q;
    if (new_grant)
      rr_d = (int'(pick_idx) == N-1) ? '0 : pick_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  assign start = rr_q;
`else
  assign start = '0;
`endif

  assign bus.gnt_o   = gnt_q;
  assign bus.idx_o   = idx_q;
  assign bus.valid_o = (state_q == ST_GRANT);
  assign bus.data_o  = data_q;

endmodule

// File: tb/tb_prio_arb_reg.sv
module tb_prio_arb_reg;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_arb_reg_if #(.N(N), .W(W)) bus ();

  prio_arb_reg #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  // reference: owner (-1 = nobody), consecutive cycles held, rotate pointer
  int         m_own;
  int         m_hold;
  int         m_rr;
  logic [W-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_hold = 0; m_rr = 0; m_data = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    int w, st;
    r = bus.req_i;
`ifdef ARB_ROUND_ROBIN_EN
    st = m_rr;
`else
    st = 0;
`endif
    if (m_own >= 0 && r[m_own] && m_hold < MH) begin
      m_hold++;
    end else begin
      if (m_own >= 0) r[m_own] = 1'b0;
      w = first_req(r, st);
      if (w >= 0) begin
        m_own = w; m_hold = 1; m_rr = (w + 1) % N;
      end else begin
        m_own = -1; m_hold = 0;
      end
    end
    m_data = (m_own >= 0) ? bus.data_i[m_own*W +: W] : '0;
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("valid", bus.valid_o, (m_own >= 0));
    chk("gnt",   bus.gnt_o,   eg);
    if (m_own >= 0) chk("idx", bus.idx_o, m_own);
    chk("data",  bus.data_o,  m_data);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_gnt",   bus.gnt_o,   0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data",  bus.data_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    bus.req_i  = '0;
    bus.data_i = '0;

    // 1: reset with all requests, first grant to index 0
    bus.req_i  = 4'b1111;
    bus.data_i = 32'h44332211;
    #12;
    chk("t1_gnt_rst",   bus.gnt_o,   0);
    chk("t1_valid_rst", bus.valid_o, 0);
    chk("t1_data_rst",  bus.data_o,  0);
    rst_n = 1'b1;
    cycle();
    chk("t1_gnt", bus.gnt_o, 4'b0001);

    // 2: priority pick with data forwarding
    do_reset();
    bus.req_i  = 4'b1010;
    bus.data_i = 32'h4433A511;
    cycle();
    chk("t2_gnt",  bus.gnt_o,  4'b0010);
    chk("t2_idx",  bus.idx_o,  1);
    chk("t2_data", bus.data_o, 8'hA5);

    // 3a: hold limit hands over to the other requester
    do_reset();
    bus.req_i = 4'b0101;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      chk("t3_gnt", bus.gnt_o, (c <= 4) ? 4'b0001 : 4'b0100);
    end
    // 3b: lone requester: 4 valid cycles, 1 idle, repeating
    do_reset();
    bus.req_i = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      chk("t3_valid", bus.valid_o, (c % 5) != 0);
    end

    // 4: owner drop, new owner gets a fresh hold count
    do_reset();
    bus.req_i = 4'b1001;
    cycle();
    chk("t4_gnt0", bus.gnt_o, 4'b0001);
    bus.req_i = 4'b1000;
    cycle();
    chk("t4_gnt3", bus.gnt_o, 4'b1000);
    for (int c = 1; c <= 4; c++) begin
      cycle();
      chk("t4_hold", bus.valid_o, c < 4);
    end

`ifdef ARB_ROUND_ROBIN_EN
    // 5: rotation among all-requesting sources
    do_reset();
    bus.req_i = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      cycle();
      chk("t5_idx", bus.idx_o, (c / MH) % N);
    end
`endif

    // 6: async reset between edges
    do_reset();
    bus.req_i = 4'b0001;
    cycle();
    cycle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_gnt",   bus.gnt_o,   0);
    chk("t6_valid", bus.valid_o, 0);
    chk("t6_data",  bus.data_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("t6_regnt", bus.gnt_o, 4'b0001);

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) bus.req_i = N'($urandom);
      bus.data_i = $urandom;
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
